// File: rtl/thermo_fill_monitor_pkg.sv
// Shared definitions for the thermometer fill monitor: FSM state encoding,
// default geometry and the legal-vector mask helper.
// The optional error counter on the top level is enabled by FILL_ERR_CNT_EN.
package thermo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_CNT_W = 8;
  localparam int ERR_CNT_W = 8;

  // Legal thermometer vector holding k ones packed from the LSB (2^k - 1).
  function automatic logic [31:0] thermo_mask(input int k);
    if (k >= 32) begin
      return '1;
    end
    return (32'd1 << k) - 32'd1;
  endfunction

endpackage

// File: rtl/thermo_fill_monitor_to_bin.sv
// Combinational thermometer-to-binary decoder. legal is set only for
// vectors of contiguous ones from the LSB; k is the count of ones in that
// case and 0 otherwise. Shared with other thermometer consumers.
module thermo_to_bin
  import thermo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LVL_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             legal,
  output logic [LVL_W-1:0] k
);

  logic [31:0] mask;

  // Compare against every legal pattern; at most one can match.
  always_comb begin
    legal = 1'b0;
    k     = '0;
    mask  = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      mask = thermo_mask(i);
      if (vec == mask[WIDTH-1:0]) begin
        legal = 1'b1;
        k     = LVL_W'(i);
      end
    end
  end

endmodule

// File: rtl/thermo_fill_monitor.sv
// Fill monitor for a thermometer-coded shift register. Each valid sample is
// decoded, checked for legality (no bubbles, level rises by at most one per
// sample, or drops straight to zero), and tracked through EMPTY/FILL/FULL/
// ERROR. Every FILL->FULL transition produces a record carrying the number
// of valid samples spent filling.
//
// Event handshake: evt_valid rises when a record is loaded and stays high,
// with evt_cycles held stable, until a rising clk edge sees evt_valid and
// evt_ready both high; that edge consumes the record. A new full event on the
// same edge as a consume is loaded; a full event while a record is still
// pending (and not being consumed) is dropped and sets the sticky overrun.
//
// clr_err takes priority over the sample in the same cycle: it returns the
// monitor to EMPTY with level 0, clears overrun and the fill counter, and
// ignores fill_in for that cycle. A pending event record is unaffected.
//
// Build option FILL_ERR_CNT_EN: adds err_count, a saturating count of
// detected errors that keeps counting while in ERROR.
module thermo_fill_monitor
  import thermo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LVL_W = $clog2(WIDTH + 1),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fill_in,
  input  logic             in_valid,
  input  logic             clr_err,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic             overrun,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_cycles,
  output logic [1:0]       state_dbg
`ifdef FILL_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam logic [LVL_W-1:0] K_FULL = LVL_W'(WIDTH);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CNT_W-1:0] evt_cycles_q, evt_cycles_d;
  logic             overrun_q, overrun_d;

  logic             dec_legal;
  logic [LVL_W-1:0] dec_k;
  logic             step_ok;
  logic             full_evt;
  logic [LVL_W:0]   k_ext;
  logic [LVL_W:0]   lvl_ext;
  logic [LVL_W:0]   lvl_inc;

  thermo_to_bin #(
    .WIDTH (WIDTH),
    .LVL_W (LVL_W)
  ) u_dec (
    .vec   (fill_in),
    .legal (dec_legal),
    .k     (dec_k)
  );

  // A sample is acceptable when it is a legal vector that holds the level,
  // rises by one, or restarts at zero.
  always_comb begin
    k_ext   = {1'b0, dec_k};
    lvl_ext = {1'b0, level_q};
    lvl_inc = lvl_ext + (LVL_W + 1)'(1);
    step_ok = dec_legal &&
              ((dec_k == '0) || (k_ext == lvl_ext) || (k_ext == lvl_inc));
  end

  // Next-state, level, fill counter and event bookkeeping.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    overrun_d    = overrun_q;
    evt_cycles_d = evt_cycles_q;
    evt_valid_d  = evt_valid_q && !evt_ready;
    full_evt     = 1'b0;

    if (clr_err) begin
      state_d   = ST_EMPTY;
      level_d   = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (in_valid && (state_q != ST_ERROR)) begin
      if (!step_ok) begin
        state_d = ST_ERROR;
      end else begin
        level_d = dec_k;
        if (dec_k == '0) begin
          state_d = ST_EMPTY;
        end else if (dec_k == K_FULL) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_FILL;
        end

        // Count every sample from leaving EMPTY up to and including the one
        // that reaches FULL; the count restarts whenever the fill drops to 0.
        if (state_d == ST_EMPTY) begin
          cnt_d = '0;
        end else if ((state_q != ST_FULL) && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        full_evt = (state_d == ST_FULL) && (state_q != ST_FULL);
      end
    end

    if (full_evt) begin
      if (!evt_valid_d) begin
        evt_valid_d  = 1'b1;
        evt_cycles_d = cnt_d;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State register; rst discards everything, including a pending record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      level_q      <= '0;
      cnt_q        <= '0;
      evt_valid_q  <= 1'b0;
      evt_cycles_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      evt_valid_q  <= evt_valid_d;
      evt_cycles_q <= evt_cycles_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef FILL_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 bad_sample;

  // Error detection here also runs in ERROR, against the held level.
  always_comb begin
    bad_sample = in_valid && !clr_err && !step_ok;
    err_cnt_d  = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (bad_sample && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign level      = level_q;
  assign empty      = (state_q == ST_EMPTY);
  assign full       = (state_q == ST_FULL);
  assign err        = (state_q == ST_ERROR);
  assign overrun    = overrun_q;
  assign evt_valid  = evt_valid_q;
  assign evt_cycles = evt_cycles_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_thermo_fill_monitor.sv
// Directed bench for thermo_fill_monitor (WIDTH=5, CNT_W=8). Inputs change
// 1 ns after the rising edge and outputs are checked there as well.
// Define FILL_ERR_CNT_EN to build and check the error counter.
module tb_thermo_fill_monitor;

  localparam int WIDTH = 5;
  localparam int LVL_W = 3;
  localparam int CNT_W = 8;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] fill_in;
  logic             in_valid;
  logic             clr_err;
  logic [LVL_W-1:0] level;
  logic             empty;
  logic             full;
  logic             err;
  logic             overrun;
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_cycles;
  logic [1:0]       state_dbg;
`ifdef FILL_ERR_CNT_EN
  logic [7:0]       err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Expected event records, oldest first.
  logic [CNT_W-1:0] exp_q[$];

  thermo_fill_monitor #(
    .WIDTH (WIDTH),
    .LVL_W (LVL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fill_in    (fill_in),
    .in_valid   (in_valid),
    .clr_err    (clr_err),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .err        (err),
    .overrun    (overrun),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_cycles (evt_cycles),
    .state_dbg  (state_dbg)
`ifdef FILL_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver: present one sample, clock it in, return 1 ns after the edge.
  task automatic step(input logic [WIDTH-1:0] vec, input logic valid);
    fill_in  = vec;
    in_valid = valid;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic fill_up(input int start_k);
    for (int k = start_k; k <= WIDTH; k++) begin
      step(WIDTH'((32'd1 << k) - 1), 1'b1);
    end
  endtask

  // Consume the pending record and match it against the oldest expectation.
  task automatic consume(input string tag);
    logic [CNT_W-1:0] exp_c;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no expected record queued", tag);
    end else begin
      exp_c = exp_q.pop_front();
      check({tag, "_valid"}, 32'(evt_valid), 32'd1);
      check({tag, "_cycles"}, 32'(evt_cycles), 32'(exp_c));
    end
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    evt_ready = 1'b0;
    check({tag, "_done"}, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    fill_in   = '0;
    in_valid  = 1'b0;
    clr_err   = 1'b0;
    evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_cycles", 32'(evt_cycles), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_EMPTY));
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef FILL_ERR_CNT_EN
    // Error counter: three illegal vectors, counting continues in ERROR.
    check("ec_init", 32'(err_count), 32'd0);
    step(5'b00101, 1'b1);
    step(5'b00110, 1'b1);
    step(5'b01001, 1'b1);
    check("ec_three", 32'(err_count), 32'd3);
    check("ec_err", 32'(err), 32'd1);
    step(5'b00010, 1'b0);
    check("ec_novalid", 32'(err_count), 32'd3);
    pulse_clr();
    check("ec_clr", 32'(err_count), 32'd0);
    check("ec_clr_empty", 32'(empty), 32'd1);
`endif

    // Normal fill 0..5.
    for (int k = 0; k <= WIDTH; k++) begin
      step(WIDTH'((32'd1 << k) - 1), 1'b1);
      check($sformatf("t1_level%0d", k), 32'(level), 32'(k));
    end
    check("t1_full", 32'(full), 32'd1);
    check("t1_evt_valid", 32'(evt_valid), 32'd1);
    check("t1_evt_cycles", 32'(evt_cycles), 32'd5);
    exp_q.push_back(8'd5);

    // Second full event while the first is unconsumed.
    step(5'b00000, 1'b1);
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_level0", 32'(level), 32'd0);
    fill_up(1);
    check("t2_full", 32'(full), 32'd1);
    check("t2_overrun", 32'(overrun), 32'd1);
    check("t2_cycles_held", 32'(evt_cycles), 32'd5);
    consume("t2_evt");

    // Bubble vector -> ERROR with level held; later samples ignored.
    step(5'b00000, 1'b1);
    step(5'b00001, 1'b1);
    step(5'b00011, 1'b1);
    step(5'b00101, 1'b1);
    check("t3_err", 32'(err), 32'd1);
    check("t3_level_hold", 32'(level), 32'd2);
    check("t3_state", 32'(state_dbg), 32'(S_ERROR));
    step(5'b00111, 1'b1);
    step(5'b00000, 1'b1);
    check("t3_ignored_err", 32'(err), 32'd1);
    check("t3_ignored_lvl", 32'(level), 32'd2);
    pulse_clr();
    check("t3_clr_empty", 32'(empty), 32'd1);
    check("t3_clr_level", 32'(level), 32'd0);
    check("t3_clr_err", 32'(err), 32'd0);
    check("t3_clr_overrun", 32'(overrun), 32'd0);

    // Step rules.
    step(5'b00001, 1'b1);
    step(5'b00111, 1'b1);
    check("t4_jump2_err", 32'(err), 32'd1);
    check("t4_jump2_lvl", 32'(level), 32'd1);
    pulse_clr();
    step(5'b00001, 1'b1);
    step(5'b00011, 1'b1);
    step(5'b00111, 1'b1);
    check("t4_fill_state", 32'(state_dbg), 32'(S_FILL));
    step(5'b00011, 1'b1);
    check("t4_down_err", 32'(err), 32'd1);
    pulse_clr();
    step(5'b00001, 1'b1);
    step(5'b00011, 1'b1);
    step(5'b00111, 1'b1);
    step(5'b00000, 1'b1);
    check("t4_restart_err", 32'(err), 32'd0);
    check("t4_restart_empty", 32'(empty), 32'd1);

    // clr_err wins over a simultaneous illegal sample.
    clr_err = 1'b1;
    step(5'b00101, 1'b1);
    clr_err = 1'b0;
    check("t4_clr_wins_err", 32'(err), 32'd0);
    check("t4_clr_wins_empty", 32'(empty), 32'd1);

    // Handshake and new full event on the same edge.
    fill_up(1);
    check("hs_first_cycles", 32'(evt_cycles), 32'd5);
    step(5'b00000, 1'b1);
    step(5'b00001, 1'b1);
    step(5'b00001, 1'b1);
    step(5'b00011, 1'b1);
    step(5'b00111, 1'b1);
    step(5'b01111, 1'b1);
    check("hs_pending", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    step(5'b11111, 1'b1);
    evt_ready = 1'b0;
    check("hs_new_valid", 32'(evt_valid), 32'd1);
    check("hs_new_cycles", 32'(evt_cycles), 32'd6);
    check("hs_no_overrun", 32'(overrun), 32'd0);
    exp_q.push_back(8'd6);
    consume("hs_evt");

    // Fill counter saturation.
    step(5'b00000, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(5'b00001, 1'b1);
    end
    fill_up(2);
    check("sat_cycles", 32'(evt_cycles), 32'd255);
    exp_q.push_back(8'd255);
    consume("sat_evt");

    // Only valid samples update; then async reset with an event pending.
    step(5'b00000, 1'b1);
    fill_up(1);
    step(5'b00000, 1'b1);
    step(5'b00001, 1'b1);
    step(5'b00011, 1'b1);
    step(5'b00111, 1'b1);
    check("t5_lvl3", 32'(level), 32'd3);
    step(5'b01111, 1'b0);
    check("t5_inval_hold", 32'(level), 32'd3);
    step(5'b01111, 1'b1);
    check("t5_valid_lvl4", 32'(level), 32'd4);
    step(5'b00000, 1'b0);
    check("t5_inval_hold4", 32'(level), 32'd4);
    check("t5_pending", 32'(evt_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_level", 32'(level), 32'd0);
    check("t5_rst_empty", 32'(empty), 32'd1);
    check("t5_rst_evt_valid", 32'(evt_valid), 32'd0);
    check("t5_rst_evt_cycles", 32'(evt_cycles), 32'd0);
    check("t5_rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    fill_up(0);
    check("t5_post_rst_cycles", 32'(evt_cycles), 32'd5);
    exp_q.push_back(8'd5);
    consume("t5_evt");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
